sv32_walk_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single `sv32_table_walk` instance. It shares the walker between the instruction-fetch and data-access translation paths. It registers the granted request toward the walker and returns the resulting PTE to the winner as a one-cycle response. It also defers TLB-flush requests until the walker is idle, so a flush never lands mid-walk.

---
 rtl/sv32_walk_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sv32_walk_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_walk_arbiter.sv
// sv32_walk_arbiter
// Shares one sv32_table_walk instance between the instruction-fetch and
// data-access translation paths. The granted request is registered toward
// the walker, and the resulting PTE is returned to the winner as a one-cycle
// response. TLB flush requests are held back until the walker is idle, so a
// flush never lands in the middle of a walk.
//
// Ports
//   clk, resetn            clock; synchronous active-low reset
//   i_valid/i_addr         instruction-side request (held until i_ready)
//   i_ready/i_pte          instruction-side one-cycle response + PTE
//   d_valid/d_addr         data-side request (held until d_ready)
//   d_ready/d_pte          data-side one-cycle response + PTE
//   flush_req/flush_done   flush request pulse / flush-issued strobe
//   tw_valid, tw_address,  registered walker request
//   tw_is_instruction
//   tw_ready/tw_pte        walker completion strobe + result
//   tw_tlb_flush           registered walker/TLB flush strobe
//   busy                   high whenever the FSM is not idle
//
// Build option
//   SV32_WALK_ARB_RR_EN    defined: round-robin on ties (last owner loses)
//                          undefined: fixed priority, D wins ties
//
// state | meaning
// IDLE  | no walk outstanding; serve a pending flush first, else grant
// BUSY  | walk outstanding, request held toward the walker
// RESP  | owner's ready strobe; no grant this cycle
// FLUSH | tw_tlb_flush / flush_done strobe

module sv32_walk_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_pte,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    output logic        d_ready,
    output logic [31:0] d_pte,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        tw_valid,
    output logic [31:0] tw_address,
    output logic        tw_is_instruction,
    input  logic        tw_ready,
    input  logic [31:0] tw_pte,
    output logic        tw_tlb_flush,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_pend;
    logic        w_pend_nx;
    logic        w_grant;
    logic        w_done;
    logic        w_d_wins;
    logic        r_owner_i;
    logic        r_i_ready;
    logic        r_d_ready;
    logic [31:0] r_i_pte;
    logic [31:0] r_d_pte;
    logic        r_tw_valid;
    logic [31:0] r_tw_addr;
    logic        r_tw_is_i;
    logic        r_flush;

`ifdef SV32_WALK_ARB_RR_EN
    // 1 = instruction side owned the last grant; reset as I so the first tie goes to D.
    logic r_last_i;

    assign w_d_wins = d_valid && (!i_valid || r_last_i);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_i <= 1'b1;
        end else if (w_grant) begin
            r_last_i <= !w_d_wins;
        end
    end
`else
    assign w_d_wins = d_valid;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_done     = 1'b0;
        w_pend_nx  = r_pend | flush_req;
        case (r_state)
            ST_IDLE: begin
                // A flush_req arriving in IDLE blocks the grant for this edge so
                // the flush is still served ahead of a simultaneous request.
                if (r_pend) begin
                    w_state_nx = ST_FLUSH;
                end else if (!flush_req && (i_valid || d_valid)) begin
                    w_grant    = 1'b1;
                    w_state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tw_ready) begin
                    w_done     = 1'b1;
                    w_state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nx = ST_IDLE;
            end
            ST_FLUSH: begin
                // Clearing here also absorbs a flush_req seen during FLUSH.
                w_pend_nx  = 1'b0;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_pend     <= 1'b0;
            r_owner_i  <= 1'b0;
            r_i_ready  <= 1'b0;
            r_d_ready  <= 1'b0;
            r_i_pte    <= 32'h0;
            r_d_pte    <= 32'h0;
            r_tw_valid <= 1'b0;
            r_tw_addr  <= 32'h0;
            r_tw_is_i  <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pend    <= w_pend_nx;
            r_i_ready <= w_done && r_owner_i;
            r_d_ready <= w_done && !r_owner_i;
            r_flush   <= (w_state_nx == ST_FLUSH);
            if (w_grant) begin
                r_tw_valid <= 1'b1;
                r_tw_addr  <= w_d_wins ? d_addr : i_addr;
                r_tw_is_i  <= !w_d_wins;
                r_owner_i  <= !w_d_wins;
            end else if (w_done) begin
                // Drop the request the cycle after completion so the walker
                // does not start a second walk.
                r_tw_valid <= 1'b0;
            end
            if (w_done && r_owner_i) begin
                r_i_pte <= tw_pte;
            end
            if (w_done && !r_owner_i) begin
                r_d_pte <= tw_pte;
            end
        end
    end

    assign i_ready           = r_i_ready;
    assign d_ready           = r_d_ready;
    assign i_pte             = r_i_pte;
    assign d_pte             = r_d_pte;
    assign tw_valid          = r_tw_valid;
    assign tw_address        = r_tw_addr;
    assign tw_is_instruction = r_tw_is_i;
    assign tw_tlb_flush      = r_flush;
    assign flush_done        = r_flush;
    assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sv32_walk_arbiter.sv
module tb_sv32_walk_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_ready;
    logic [31:0] i_pte;
    logic        d_valid = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic        d_ready;
    logic [31:0] d_pte;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic        tw_valid;
    logic [31:0] tw_address;
    logic        tw_is_instruction;
    logic        tw_ready = 1'b0;
    logic [31:0] tw_pte = 32'h0;
    logic        tw_tlb_flush;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int flushes = 0;

    sv32_walk_arbiter dut (
        .clk               (clk),
        .resetn            (resetn),
        .i_valid           (i_valid),
        .i_addr            (i_addr),
        .i_ready           (i_ready),
        .i_pte             (i_pte),
        .d_valid           (d_valid),
        .d_addr            (d_addr),
        .d_ready           (d_ready),
        .d_pte             (d_pte),
        .flush_req         (flush_req),
        .flush_done        (flush_done),
        .tw_valid          (tw_valid),
        .tw_address        (tw_address),
        .tw_is_instruction (tw_is_instruction),
        .tw_ready          (tw_ready),
        .tw_pte            (tw_pte),
        .tw_tlb_flush      (tw_tlb_flush),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock, sample 1 ns after the edge, and count flush strobes seen.
    task automatic tick;
        @(posedge clk);
        #1;
        if (tw_tlb_flush) flushes++;
    endtask

    // Complete the walk currently granted and return to IDLE.
    task automatic drain;
        tw_ready = 1'b1;
        tw_pte   = 32'h5555_0000;
        tick();
        tw_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick();
        tick();
        vectors++; if ({i_ready, d_ready, flush_done, tw_valid, tw_is_instruction, tw_tlb_flush, busy} !== 7'b0) begin miscompares++; $display("FAIL reset_flags got=%b exp=0000000", {i_ready, d_ready, flush_done, tw_valid, tw_is_instruction, tw_tlb_flush, busy}); end
        vectors++; if (i_pte !== 32'h0) begin miscompares++; $display("FAIL reset_i_pte got=%h exp=0", i_pte); end
        vectors++; if (d_pte !== 32'h0) begin miscompares++; $display("FAIL reset_d_pte got=%h exp=0", d_pte); end
        vectors++; if (tw_address !== 32'h0) begin miscompares++; $display("FAIL reset_tw_address got=%h exp=0", tw_address); end
    endtask

    task automatic test_tie;
        logic        exp_i;
        logic [31:0] exp_pte;
        resetn  = 1'b1;
        i_valid = 1'b1;
        d_valid = 1'b1;
        i_addr  = 32'h0040_0000;
        d_addr  = 32'h1000_2000;
        tick();
        for (int w = 0; w < 4; w++) begin
`ifdef SV32_WALK_ARB_RR_EN
            exp_i = (w % 2 == 1);
`else
            exp_i = 1'b0;
`endif
            exp_pte = 32'hA000_0000 + w;
            vectors++; if ({tw_valid, tw_is_instruction} !== {1'b1, exp_i}) begin miscompares++; $display("FAIL tie_grant%0d got valid/is_i=%b exp=%b", w, {tw_valid, tw_is_instruction}, {1'b1, exp_i}); end
            vectors++; if (tw_address !== (exp_i ? 32'h0040_0000 : 32'h1000_2000)) begin miscompares++; $display("FAIL tie_addr%0d got=%h", w, tw_address); end
            tw_ready = 1'b1;
            tw_pte   = exp_pte;
            tick();
            tw_ready = 1'b0;
            vectors++; if ({tw_valid, i_ready, d_ready} !== {1'b0, exp_i, !exp_i}) begin miscompares++; $display("FAIL tie_resp%0d got valid/ir/dr=%b exp=%b", w, {tw_valid, i_ready, d_ready}, {1'b0, exp_i, !exp_i}); end
            vectors++; if ((exp_i ? i_pte : d_pte) !== exp_pte) begin miscompares++; $display("FAIL tie_pte%0d got=%h exp=%h", w, (exp_i ? i_pte : d_pte), exp_pte); end
            tick();
            vectors++; if ({tw_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL tie_idle%0d got valid/busy=%b exp=00", w, {tw_valid, busy}); end
            tick();
        end
        vectors++; if ({tw_valid, tw_is_instruction} !== 2'b10) begin miscompares++; $display("FAIL tie_grant4 got valid/is_i=%b exp=10", {tw_valid, tw_is_instruction}); end
`ifdef SV32_WALK_ARB_RR_EN
        exp_pte = 32'hA000_0003;
`else
        exp_pte = 32'h0;
`endif
        vectors++; if (i_pte !== exp_pte) begin miscompares++; $display("FAIL tie_i_pte got=%h exp=%h", i_pte, exp_pte); end
        i_valid = 1'b0;
        d_valid = 1'b0;
        drain();
    endtask

    task automatic test_single;
        i_addr  = 32'h8040_1000;
        i_valid = 1'b1;
        tick();
        vectors++; if ({tw_valid, tw_is_instruction, busy} !== 3'b111) begin miscompares++; $display("FAIL single_grant got valid/is_i/busy=%b exp=111", {tw_valid, tw_is_instruction, busy}); end
        vectors++; if (tw_address !== 32'h8040_1000) begin miscompares++; $display("FAIL single_addr got=%h exp=80401000", tw_address); end
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++; if ({tw_valid, tw_address} !== {1'b1, 32'h8040_1000}) begin miscompares++; $display("FAIL single_hold%0d got valid=%b addr=%h", c, tw_valid, tw_address); end
        end
        tw_ready = 1'b1;
        tw_pte   = 32'h2010_00CF;
        tick();
        tw_ready = 1'b0;
        vectors++; if ({tw_valid, i_ready, d_ready} !== 3'b010) begin miscompares++; $display("FAIL single_resp got valid/ir/dr=%b exp=010", {tw_valid, i_ready, d_ready}); end
        vectors++; if (i_pte !== 32'h2010_00CF) begin miscompares++; $display("FAIL single_i_pte got=%h exp=201000cf", i_pte); end
        vectors++; if (d_pte !== 32'h5555_0000) begin miscompares++; $display("FAIL single_d_pte_hold got=%h exp=55550000", d_pte); end
        i_valid = 1'b0;
        tick();
        vectors++; if ({i_ready, busy} !== 2'b00) begin miscompares++; $display("FAIL single_after got ir/busy=%b exp=00", {i_ready, busy}); end
    endtask

    task automatic test_flush_idle;
        flushes   = 0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        vectors++; if ({tw_tlb_flush, busy} !== 2'b00) begin miscompares++; $display("FAIL flush_idle_k1 got flush/busy=%b exp=00", {tw_tlb_flush, busy}); end
        tick();
        vectors++; if ({tw_tlb_flush, flush_done, busy} !== 3'b111) begin miscompares++; $display("FAIL flush_idle_k2 got flush/done/busy=%b exp=111", {tw_tlb_flush, flush_done, busy}); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        tick();
        vectors++; if (flushes !== 1) begin miscompares++; $display("FAIL flush_absorb got count=%0d exp=1", flushes); end
        // flush and request together: flush first
        flush_req = 1'b1;
        i_valid   = 1'b1;
        i_addr    = 32'h0000_3000;
        tick();
        flush_req = 1'b0;
        vectors++; if (tw_valid !== 1'b0) begin miscompares++; $display("FAIL simul_no_grant got=%b exp=0", tw_valid); end
        tick();
        vectors++; if ({tw_tlb_flush, tw_valid} !== 2'b10) begin miscompares++; $display("FAIL simul_flush got flush/valid=%b exp=10", {tw_tlb_flush, tw_valid}); end
        tick();
        tick();
        vectors++; if ({tw_valid, tw_is_instruction, tw_address} !== {2'b11, 32'h0000_3000}) begin miscompares++; $display("FAIL simul_grant got valid=%b is_i=%b addr=%h", tw_valid, tw_is_instruction, tw_address); end
        tw_ready = 1'b1;
        tw_pte   = 32'h0000_7777;
        tick();
        tw_ready = 1'b0;
        i_valid  = 1'b0;
        vectors++; if ({i_ready, i_pte} !== {1'b1, 32'h0000_7777}) begin miscompares++; $display("FAIL simul_resp got ir=%b pte=%h", i_ready, i_pte); end
        tick();
    endtask

    task automatic test_flush_during_walk;
        flushes = 0;
        d_valid = 1'b1;
        d_addr  = 32'h2000_4000;
        tick();
        vectors++; if ({tw_valid, tw_is_instruction} !== 2'b10) begin miscompares++; $display("FAIL fdw_grant got valid/is_i=%b exp=10", {tw_valid, tw_is_instruction}); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        tick();
        vectors++; if ({tw_tlb_flush, busy, tw_valid} !== 3'b011) begin miscompares++; $display("FAIL fdw_busy got flush/busy/valid=%b exp=011", {tw_tlb_flush, busy, tw_valid}); end
        tw_ready = 1'b1;
        tw_pte   = 32'hDD00_0001;
        tick();
        tw_ready = 1'b0;
        d_valid  = 1'b0;
        vectors++; if ({d_ready, tw_tlb_flush, d_pte} !== {2'b10, 32'hDD00_0001}) begin miscompares++; $display("FAIL fdw_resp got dr=%b flush=%b pte=%h", d_ready, tw_tlb_flush, d_pte); end
        tick();
        vectors++; if ({tw_tlb_flush, busy} !== 2'b00) begin miscompares++; $display("FAIL fdw_idle got flush/busy=%b exp=00", {tw_tlb_flush, busy}); end
        tick();
        vectors++; if ({tw_tlb_flush, flush_done} !== 2'b11) begin miscompares++; $display("FAIL fdw_flush got flush/done=%b exp=11", {tw_tlb_flush, flush_done}); end
        tick();
        vectors++; if ({flushes, busy} !== {32'sd1, 1'b0}) begin miscompares++; $display("FAIL fdw_count got count=%0d busy=%b exp 1/0", flushes, busy); end
    endtask

    task automatic test_merged;
        flushes = 0;
        i_valid = 1'b1;
        i_addr  = 32'h0000_5000;
        tick();
        vectors++; if ({tw_valid, tw_is_instruction} !== 2'b11) begin miscompares++; $display("FAIL merged_grant got valid/is_i=%b exp=11", {tw_valid, tw_is_instruction}); end
        d_valid = 1'b1;
        d_addr  = 32'h3000_6000;
        for (int p = 0; p < 3; p++) begin
            flush_req = 1'b1;
            tick();
            flush_req = 1'b0;
            tick();
        end
        tw_ready = 1'b1;
        tw_pte   = 32'h1111_2222;
        tick();
        tw_ready = 1'b0;
        i_valid  = 1'b0;
        vectors++; if ({i_ready, d_ready} !== 2'b10) begin miscompares++; $display("FAIL merged_resp got ir/dr=%b exp=10", {i_ready, d_ready}); end
        tick();
        vectors++; if ({tw_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL merged_idle got valid/busy=%b exp=00", {tw_valid, busy}); end
        tick();
        vectors++; if ({tw_tlb_flush, tw_valid} !== 2'b10) begin miscompares++; $display("FAIL merged_flush got flush/valid=%b exp=10", {tw_tlb_flush, tw_valid}); end
        tick();
        vectors++; if (tw_valid !== 1'b0) begin miscompares++; $display("FAIL merged_idle2 got valid=%b exp=0", tw_valid); end
        tick();
        vectors++; if ({tw_valid, tw_is_instruction, tw_address} !== {2'b10, 32'h3000_6000}) begin miscompares++; $display("FAIL merged_d_grant got valid=%b is_i=%b addr=%h", tw_valid, tw_is_instruction, tw_address); end
        vectors++; if (flushes !== 1) begin miscompares++; $display("FAIL merged_count got=%0d exp=1", flushes); end
        d_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_walk;
        d_valid = 1'b1;
        d_addr  = 32'h4000_0000;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        vectors++; if ({i_ready, d_ready, flush_done, tw_valid, tw_is_instruction, tw_tlb_flush, busy} !== 7'b0) begin miscompares++; $display("FAIL rst_mid_flags got=%b exp=0000000", {i_ready, d_ready, flush_done, tw_valid, tw_is_instruction, tw_tlb_flush, busy}); end
        vectors++; if ({i_pte, d_pte, tw_address} !== 96'h0) begin miscompares++; $display("FAIL rst_mid_data got i_pte=%h d_pte=%h addr=%h", i_pte, d_pte, tw_address); end
        resetn  = 1'b1;
        d_valid = 1'b0;
        i_valid = 1'b1;
        i_addr  = 32'h8000_0000;
        tick();
        vectors++; if ({tw_valid, tw_is_instruction, tw_address} !== {2'b11, 32'h8000_0000}) begin miscompares++; $display("FAIL rst_mid_grant got valid=%b is_i=%b addr=%h", tw_valid, tw_is_instruction, tw_address); end
        tw_ready = 1'b1;
        tw_pte   = 32'hC0FF_EE01;
        tick();
        tw_ready = 1'b0;
        i_valid  = 1'b0;
        vectors++; if ({i_ready, i_pte} !== {1'b1, 32'hC0FF_EE01}) begin miscompares++; $display("FAIL rst_mid_resp got ir=%b pte=%h", i_ready, i_pte); end
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_flush_idle();
        test_flush_during_walk();
        test_merged();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
